// File: rtl/gemm_result_drain_if.sv
// ---------------------------------------------------------------------------
// gemm_result_drain_if
// Bundles the control, BUFFER_C read-port and result-stream signals of the
// GEMM result drain engine.
//   master : the drain engine (drives status, SRAM read strobe/address and the
//            output stream; receives start/dims, SRAM data and out_ready)
//   slave  : the surrounding system (controller, BUFFER_C and stream sink)
// ---------------------------------------------------------------------------
interface gemm_result_drain_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    // control
    logic                  start;
    logic [7:0]            M_dimension;
    logic [7:0]            N_dimension;
    logic                  busy;
    logic                  done;
    // BUFFER_C read port
    logic                  read_enable_C;
    logic [ADDR_WIDTH-1:0] address_C;
    logic [DATA_WIDTH-1:0] data_out_C;
    // result stream
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  start, M_dimension, N_dimension, data_out_C, out_ready,
        output busy, done, read_enable_C, address_C,
               out_valid, out_data, out_last
    );

    modport slave (
        output start, M_dimension, N_dimension, data_out_C, out_ready,
        input  busy, done, read_enable_C, address_C,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/gemm_result_drain.sv
// ---------------------------------------------------------------------------
// gemm_result_drain
// Walks the M x N result matrix in BUFFER_C in row-major order, issuing
// one-cycle-latency SRAM reads, and streams each element out over a
// valid/ready interface with the final element flagged by out_last.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : gemm_result_drain_if.master
//            start/M_dimension/N_dimension -> drain request and dims
//            busy/done                     -> status, done is a 1-cycle pulse
//            read_enable_C/address_C       -> SRAM read strobe and address
//            data_out_C                    -> SRAM data, valid cycle after read
//            out_valid/out_data/out_last   -> result stream
//            out_ready                     -> stream sink accept
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start
//   S_ISSUE | issuing reads while read credit is available
//   S_FLUSH | all reads issued; waiting for in-flight read and FIFO to drain
//   S_DONE  | one-cycle done pulse, then back to idle
// ---------------------------------------------------------------------------
module gemm_result_drain #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    gemm_result_drain_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [7:0]            m_q, m_d;
    logic [7:0]            n_q, n_d;
    logic [7:0]            row_q, row_d;
    logic [7:0]            col_q, col_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // one read may be in flight (SRAM latency of one cycle)
    logic                  inflight_q;
    logic                  inflight_last_q;

    // two-entry output FIFO
    logic [DATA_WIDTH-1:0] data_mem_q [2];
    logic                  last_mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q, count_d;

    logic                  push;
    logic                  pop;
    logic                  out_valid;
    logic [2:0]            occ_after_pop;
    logic                  issue;
    logic                  col_wrap;
    logic                  read_last;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & bus.out_ready;
    assign push      = inflight_q;

    // Occupancy left once this cycle's pop is taken; a new read is allowed
    // only if it still fits, so FIFO entries + in-flight never exceed two.
    assign occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue         = (state_q == S_ISSUE) && (occ_after_pop < 3'd2);

    assign col_wrap  = (col_q == n_q - 8'd1);
    assign read_last = col_wrap && (row_q == m_q - 8'd1);

    assign count_d = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d    = bus.M_dimension;
                    n_d    = bus.N_dimension;
                    row_d  = 8'd0;
                    col_d  = 8'd0;
                    addr_d = '0;
                    // A zero-sized drain passes through FLUSH, which exits at
                    // once with nothing outstanding; this places the done
                    // pulse two cycles after start, as for any drain's tail.
                    if (bus.M_dimension == 8'd0 || bus.N_dimension == 8'd0)
                        state_d = S_FLUSH;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (col_wrap) begin
                        col_d = 8'd0;
                        row_d = row_q + 8'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                    if (read_last)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // leave as soon as the FIFO will be empty after this cycle
                if (!inflight_q && count_d == 2'd0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            m_q             <= 8'd0;
            n_q             <= 8'd0;
            row_q           <= 8'd0;
            col_q           <= 8'd0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_mem_q[i] <= '0;
                last_mem_q[i] <= 1'b0;
            end
        end else begin
            state_q         <= state_d;
            m_q             <= m_d;
            n_q             <= n_d;
            row_q           <= row_d;
            col_q           <= col_d;
            addr_q          <= addr_d;
            inflight_q      <= issue;
            inflight_last_q <= issue & read_last;
            count_q         <= count_d;
            if (push) begin
                data_mem_q[wr_ptr_q] <= bus.data_out_C;
                last_mem_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.read_enable_C = issue;
    assign bus.address_C     = addr_q;
    assign bus.out_valid     = out_valid;
    assign bus.out_data      = data_mem_q[rd_ptr_q];
    assign bus.out_last      = out_valid & last_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_gemm_result_drain.sv
// ---------------------------------------------------------------------------
// tb_gemm_result_drain
// Directed bench for gemm_result_drain. BUFFER_C holds C[a] = a + 100, so
// beat k of any drain must carry k + 100 and read k must use address k.
// ---------------------------------------------------------------------------
module tb_gemm_result_drain;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gemm_result_drain_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    gemm_result_drain #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // free-running cycle counter
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // out_ready driver: 0 = always high, 1 = 1,0,0,1 pattern, 2 = random
    int ready_mode = 0;
    initial begin
        logic [3:0] pat;
        int pidx;
        pat  = 4'b1001;
        pidx = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       begin bus.out_ready = pat[pidx % 4]; pidx++; end
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // BUFFER_C model: data valid the cycle after read_enable_C
    initial begin
        logic        r;
        logic [15:0] a;
        bus.data_out_C = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            r = bus.read_enable_C;
            a = bus.address_C;
            @(posedge clk);
            #1;
            if (r) bus.data_out_C = {16'h0, a} + 32'd100;
            else   bus.data_out_C = 32'hDEAD_BEEF;
        end
    end

    // stream / read-port monitor
    logic mon_en = 1'b0;
    int   total = 0;
    int   beat_idx = 0;
    int   read_idx = 0;
    int   done_count = 0;
    int   done_rel = -1;
    int   start_cyc = 0;

    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    chk("stall_valid_held", bus.out_valid, 1'b1);
                    chk("stall_data_held", bus.out_data, prev_data);
                    chk("stall_last_held", bus.out_last, prev_last);
                end
                if (bus.read_enable_C) begin
                    chk("rd_addr", bus.address_C, 64'(read_idx & 32'hFFFF));
                    read_idx++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (beat_idx >= total) begin
                        chk("extra_beat", beat_idx, total - 1);
                    end else begin
                        chk("beat_data", bus.out_data, 64'(beat_idx + 100));
                        chk("beat_last", bus.out_last, (beat_idx == total - 1));
                    end
                    beat_idx++;
                end
                if (read_idx - beat_idx > 2)
                    chk("outstanding_le2", read_idx - beat_idx, 2);
                if (bus.done) begin
                    done_count++;
                    done_rel = cyc - start_cyc;
                end
                prev_stall = bus.out_valid & ~bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic start_drain(input int m, input int n);
        @(posedge clk);
        #1;
        total      = m * n;
        beat_idx   = 0;
        read_idx   = 0;
        done_count = 0;
        done_rel   = -1;
        start_cyc  = cyc;
        mon_en     = 1'b1;
        bus.start       = 1'b1;
        bus.M_dimension = 8'(m);
        bus.N_dimension = 8'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int exp_beats, input int exp_done);
        int bound;
        bound = (ready_mode == 0) ? exp_beats + 20 : 4 * exp_beats + 50;
        for (int i = 0; i < bound && done_count == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", done_count, 1);
        if (exp_done >= 0)
            chk("done_cycle", done_rel, exp_done);
        chk("beat_count", beat_idx, exp_beats);
        chk("read_count", read_idx, exp_beats);
        @(posedge clk);
        #1;
        chk("busy_after_done", bus.busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", done_count, 1);
        mon_en = 1'b0;
    endtask

    typedef struct {
        int m;
        int n;
        int mode;
        int exp_beats;
        int exp_done;  // -1 when throughput depends on out_ready
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{m: 4, n: 4, mode: 0, exp_beats: 16, exp_done: 19};
        vecs[1] = '{m: 2, n: 3, mode: 1, exp_beats: 6,  exp_done: -1};
        vecs[2] = '{m: 2, n: 3, mode: 2, exp_beats: 6,  exp_done: -1};
        vecs[3] = '{m: 0, n: 5, mode: 0, exp_beats: 0,  exp_done: 2};
        vecs[4] = '{m: 1, n: 1, mode: 0, exp_beats: 1,  exp_done: 4};
        vecs[5] = '{m: 3, n: 5, mode: 0, exp_beats: 15, exp_done: 18};
        vecs[6] = '{m: 5, n: 0, mode: 0, exp_beats: 0,  exp_done: 2};

        bus.start       = 1'b0;
        bus.M_dimension = 8'd0;
        bus.N_dimension = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_re", bus.read_enable_C, 1'b0);
        chk("rst_addr", bus.address_C, 0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_last", bus.out_last, 1'b0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            ready_mode = vecs[v].mode;
            start_drain(vecs[v].m, vecs[v].n);
            wait_drain(vecs[v].exp_beats, vecs[v].exp_done);
        end
        ready_mode = 0;

        // start while busy is ignored: 3x3 drain keeps its dims
        start_drain(3, 3);
        repeat (3) @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.M_dimension = 8'd1;
        bus.N_dimension = 8'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain(9, 12);

        // reset after three beats of a 4x4 drain
        start_drain(4, 4);
        for (int i = 0; i < 40 && beat_idx < 3; i++) begin
            @(negedge clk);
            #1;
        end
        chk("reached_3_beats", beat_idx, 3);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_done", bus.done, 1'b0);
        chk("mid_rst_re", bus.read_enable_C, 1'b0);
        chk("mid_rst_addr", bus.address_C, 0);
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_last", bus.out_last, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", bus.done, 1'b0);
            chk("post_rst_no_valid", bus.out_valid, 1'b0);
        end
        start_drain(2, 2);
        wait_drain(4, 7);

        // maximum size
        start_drain(255, 255);
        wait_drain(65025, 65028);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
